// File: rtl/ascii_pkg.sv
// Shared state type and character-class constants for the ASCII-to-word packer.
package ascii_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    localparam logic [7:0] DEF_TERM_CHAR = 8'h0A;
    localparam logic [7:0] PRINT_LO      = 8'h20;
    localparam logic [7:0] PRINT_HI      = 8'h7E;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/ascii_to_byte.sv
// Packs a valid/ready ASCII char stream MSB-first into NUM_CHARS-char words.
// Optional non-printable filter enabled by defining ASCII_FILTER_EN.
module ascii_to_byte
    import ascii_pkg::*;
#(
    parameter int                NUM_CHARS = 6,
    parameter int                CHAR_W    = 8,
    parameter logic [CHAR_W-1:0] TERM_CHAR = DEF_TERM_CHAR
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CHAR_W-1:0]                  char_in,
    input  logic                               char_valid,
    output logic                               char_ready,
    output logic [NUM_CHARS*CHAR_W-1:0]        data_out,
    output logic                               dataValid,
    output logic [$clog2(NUM_CHARS+1)-1:0]     data_len,
    output logic                               err_nonprint
);

    localparam int DATA_W = NUM_CHARS * CHAR_W;
    localparam int CNT_W  = $clog2(NUM_CHARS + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [CNT_W-1:0]  r_len;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_aligned;
    logic              r_ready_en;
    logic              w_accept;
    logic              w_is_term;
    logic              w_bad;
    logic              w_load;
    int                w_shamt;

    assign w_accept  = char_valid && char_ready;
    assign w_is_term = (char_in == TERM_CHAR);

`ifdef ASCII_FILTER_EN
    assign w_bad = !is_printable(char_in);
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        case (r_state)
            IDLE, COLLECT: begin
                if (w_accept) begin
                    if (w_is_term) begin
                        if (r_count != '0) begin
                            w_state_next = EMIT;
                            w_load       = 1'b1;
                        end
                    end else if (!w_bad) begin
                        w_shift_next = {r_shift[DATA_W-CHAR_W-1:0], char_in};
                        w_count_next = r_count + CNT_W'(1);
                        if (w_count_next == CNT_W'(NUM_CHARS)) begin
                            w_state_next = EMIT;
                            w_load       = 1'b1;
                        end else begin
                            w_state_next = COLLECT;
                        end
                    end
                end
            end
            EMIT: begin
                w_state_next = IDLE;
                w_count_next = '0;
                w_shift_next = '0;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Chars shift in at the LSB end; left-align so the first char lands in the top byte.
    always_comb begin
        w_shamt   = CHAR_W * (NUM_CHARS - int'(w_count_next));
        w_aligned = w_shift_next << w_shamt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_len      <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_shift    <= w_shift_next;
            if (w_load) begin
                r_data <= w_aligned;
                r_len  <= w_count_next;
            end
        end
    end

`ifdef ASCII_FILTER_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_is_term && w_bad;
        end
    end

    assign err_nonprint = r_err;
`else
    assign err_nonprint = 1'b0;
`endif

    assign char_ready = r_ready_en && (r_state != EMIT);
    assign dataValid  = (r_state == EMIT);
    assign data_out   = r_data;
    assign data_len   = r_len;

endmodule
